icache_direct_mapped: RTL and testbench



---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_line_store.sv | 41 ++++
 rtl/icache_direct_mapped.sv | 101 ++++++++++
 tb/tb_icache_direct_mapped.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned NUM_BLOCKS = 8;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned TAG_W      = 3;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned WORD_W     = 2;
    localparam int unsigned MEM_ADDR_W = TAG_W + IDX_W;

    localparam int unsigned TAG_MSB  = 9;
    localparam int unsigned TAG_LSB  = 7;
    localparam int unsigned IDX_MSB  = 6;
    localparam int unsigned IDX_LSB  = 4;
    localparam int unsigned WORD_MSB = 3;
    localparam int unsigned WORD_LSB = 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_READ = 2'd1;
    localparam logic [1:0] ST_UPDATE   = 2'd2;

    // Latched miss target; its packed layout is exactly the memory block address.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
    } miss_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: async-cleared valid bits, single fill port, async indexed read.
module icache_line_store
    import icache_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               fill_en,
    input  logic [IDX_W-1:0]   fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data,
    input  logic [IDX_W-1:0]   rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_W-1:0]      tag_array  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_array [NUM_BLOCKS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid alone gates their use.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_array[fill_index]  <= fill_tag;
            data_array[fill_index] <= fill_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_array[rd_index];
    assign rd_data  = data_array[rd_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache; fills 16-byte lines from instruct_memory on a miss.
module icache_direct_mapped
    import icache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic [ADDR_W-1:0]     address,
    output logic [INST_W-1:0]     readinst,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    logic [1:0]         state;
    logic [1:0]         state_next;
    miss_t              miss;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_index;
    logic [WORD_W-1:0]  req_word;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               hit;
    logic               fill_en;
    logic               unused_byte_offset;

    assign req_tag            = address[TAG_MSB:TAG_LSB];
    assign req_index          = address[IDX_MSB:IDX_LSB];
    assign req_word           = address[WORD_MSB:WORD_LSB];
    assign unused_byte_offset = ^address[1:0];

    icache_line_store u_line_store (
        .clock      (clock),
        .reset      (reset),
        .fill_en    (fill_en),
        .fill_index (miss.index),
        .fill_tag   (miss.tag),
        .fill_data  (mem_readdata),
        .rd_index   (req_index),
        .rd_valid   (line_valid),
        .rd_tag     (line_tag),
        .rd_data    (line_data)
    );

    assign hit      = line_valid && (line_tag == req_tag);
    assign readinst = hit ? line_data[{req_word, 5'd0} +: INST_W] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The fill always lands where the miss was taken, whatever the CPU does meanwhile.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss <= '0;
        end else if (state == ST_IDLE && read && !hit) begin
            miss <= '{tag: req_tag, index: req_index};
        end
    end

    assign mem_address = miss;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (read && !hit) state_next = ST_MEM_READ;
            ST_MEM_READ: if (!mem_busywait) state_next = ST_UPDATE;
            ST_UPDATE:   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busywait = 1'b0;
        mem_read = 1'b0;
        fill_en  = 1'b0;
        case (state)
            ST_IDLE:     busywait = read && !hit;
            ST_MEM_READ: begin
                busywait = 1'b1;
                mem_read = 1'b1;
            end
            ST_UPDATE:   begin
                busywait = 1'b1;
                fill_en  = 1'b1;
            end
            default:     busywait = 1'b0;
        endcase
        if (reset) begin
            busywait = 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped with a fixed-latency block-read memory model.
module tb_icache_direct_mapped;

    localparam int MEM_LAT  = 2;
    // Address applied at a negedge -> MEM_READ entry edge, MEM_LAT busy edges, exit edge, UPDATE edge.
    localparam int MISS_NEG = MEM_LAT + 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         read = 1'b0;
    logic [9:0]   address = '0;
    logic [31:0]  readinst;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;

    int checks = 0;
    int failures = 0;
    int lat_cnt = 0;

    icache_direct_mapped dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readinst     (readinst),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] inst_word(input int i);
        case (i)
            0:       return 32'h0900_0001;
            1:       return 32'h0000_000C;
            8:       return 32'h0805_0000;
            10:      return 32'h0B00_0438;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    function automatic logic [127:0] block_of(input logic [5:0] b);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = inst_word(int'(b) * 4 + k);
        return r;
    endfunction

    // Memory: holds mem_busywait high for MEM_LAT cycles of a request, then presents the block.
    always begin
        @(posedge clock);
        #1;
        if (reset || !mem_read) begin
            lat_cnt = 0;
            mem_busywait = 1'b0;
        end else if (lat_cnt < MEM_LAT) begin
            lat_cnt++;
            mem_busywait = 1'b1;
        end else begin
            mem_busywait = 1'b0;
            mem_readdata = block_of(mem_address);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for busywait to fall, tracking mem_address stability while mem_read is high.
    task automatic wait_idle(input logic [5:0] ma, output int cyc, output logic seen, output logic addr_ok);
        cyc = 0;
        seen = 1'b0;
        addr_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            cyc++;
            if (mem_read) begin
                seen = 1'b1;
                if (mem_address !== ma) addr_ok = 1'b0;
            end
            if (!busywait) break;
        end
    endtask

    task automatic miss_access(input string tag, input logic [9:0] a, input logic [5:0] ma,
                               input logic [31:0] inst);
        int cyc;
        logic seen, ok;
        read = 1'b1;
        address = a;
        #1;
        check({tag, "_busy"}, 32'(busywait), 32'd1);
        wait_idle(ma, cyc, seen, ok);
        check({tag, "_memread_seen"}, 32'(seen), 32'd1);
        check({tag, "_memaddr"}, 32'(ok), 32'd1);
        check({tag, "_penalty"}, 32'(cyc), 32'(MISS_NEG));
        check({tag, "_done"}, 32'(busywait), 32'd0);
        check({tag, "_inst"}, readinst, inst);
    endtask

    task automatic hit_access(input string tag, input logic [9:0] a, input logic [31:0] inst);
        read = 1'b1;
        address = a;
        #1;
        check({tag, "_busy"}, 32'(busywait), 32'd0);
        check({tag, "_inst"}, readinst, inst);
        check({tag, "_memread"}, 32'(mem_read), 32'd0);
        @(negedge clock);
        check({tag, "_memread_next"}, 32'(mem_read), 32'd0);
    endtask

    initial begin
        int cyc;
        logic seen, ok, stable;

        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busywait), 32'd0);
        check("rst_memread", 32'(mem_read), 32'd0);
        check("rst_memaddr", 32'(mem_address), 32'd0);
        check("rst_inst", readinst, 32'd0);
        reset = 1'b0;

        miss_access("cold", 10'h000, 6'h00, 32'h0900_0001);
        hit_access("same_blk", 10'h004, 32'h0000_000C);
        miss_access("blk2", 10'h028, 6'h02, 32'h0B00_0438);
        hit_access("blk2_w0", 10'h020, 32'h0805_0000);
        miss_access("conflict", 10'h080, 6'h08, 32'hC0DE_0020);
        miss_access("evicted", 10'h000, 6'h00, 32'h0900_0001);
        miss_access("top", 10'h3FC, 6'h3F, 32'hC0DE_00FF);

        // read drops mid-miss: the fill still completes
        read = 1'b1;
        address = 10'h040;
        repeat (2) @(negedge clock);
        read = 1'b0;
        #1;
        check("drop_busy", 32'(busywait), 32'd1);
        wait_idle(6'h04, cyc, seen, ok);
        check("drop_memaddr", 32'(ok), 32'd1);
        check("drop_done", 32'(busywait), 32'd0);
        hit_access("drop_filled", 10'h040, 32'hC0DE_0010);

        // address changes mid-miss: fill targets index 1, then 0x030 misses on its own
        read = 1'b1;
        address = 10'h010;
        repeat (2) @(negedge clock);
        check("chg_memread", 32'(mem_read), 32'd1);
        check("chg_memaddr", 32'(mem_address), 32'h01);
        address = 10'h030;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!mem_read) break;
            if (mem_address !== 6'h01) stable = 1'b0;
        end
        check("chg_held", 32'(stable), 32'd1);
        check("chg_update_busy", 32'(busywait), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (mem_read) break;
        end
        check("chg_remiss_memread", 32'(mem_read), 32'd1);
        check("chg_remiss_memaddr", 32'(mem_address), 32'h03);
        wait_idle(6'h03, cyc, seen, ok);
        check("chg_remiss_done", 32'(busywait), 32'd0);
        check("chg_remiss_inst", readinst, 32'hC0DE_000C);
        hit_access("chg_old_filled", 10'h010, 32'hC0DE_0004);

        // reset during MEM_READ
        read = 1'b1;
        address = 10'h100;
        repeat (2) @(negedge clock);
        check("rstmid_memread", 32'(mem_read), 32'd1);
        check("rstmid_memaddr", 32'(mem_address), 32'h10);
        reset = 1'b1;
        #1;
        check("rstmid_memread_off", 32'(mem_read), 32'd0);
        check("rstmid_busy_off", 32'(busywait), 32'd0);
        check("rstmid_inst", readinst, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        miss_access("post_rst", 10'h000, 6'h00, 32'h0900_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
